round_judge: RTL
================

Name: round_judge

Overview:
- Sits downstream of input_trim: consumes the trimmed button sequence and the pattern from pattern_generator.
- Launched by input_trim's end pulse; compares entries one per cycle over the level-dependent length.
- Accumulates score across rounds; pulses round_end so the pattern can be regenerated; flags game_over after NUM_ROUNDS.

Parameters:
- NUM_ROUNDS, 10, rounds per game before game_over.
- LEN_LV1, 4, entries judged at level 001.
- LEN_LV2, 8, entries judged at level 010.
- LEN_LV3, 16, entries judged at level 100; must be ≤16.
- SCORE_W, 8, total_score width; 10*16=160 fits.

Ports:
- clk  in  1  system clock (fast clock); the only clock.
- rst  in  1  asynchronous, active-low reset; driven from level_select.
- enable  in  1  one-cycle start pulse (input_trim end_signal).
- level  in  3  one-hot level: 001, 010 or 100; 000 means invalid.
- pattern_flat  in  48  pattern entry k at bits [3k+2:3k], values 0..7.
- input_flat  in  48  trimmed input entry k at [3k+2:3k], same encoding.
- busy  out  1  high while in CAPTURE..DONE.
- round_end  out  1  one-cycle pulse when a round is judged.
- round_hits  out  5  matching entries in the last round (0..16).
- round_perfect  out  1  last round had hits == length.
- total_score  out  SCORE_W  saturating sum of hits over the game.
- round_cnt  out  4  rounds judged so far (0..NUM_ROUNDS).
- game_over  out  1  sticky; high once round_cnt == NUM_ROUNDS.
- level_err  out  1  one-cycle pulse: enable arrived with an invalid level.

Behaviour:
- Reset (rst low, async): state IDLE; every output 0; capture registers cleared.
- State IDLE:
  - Accept enable only when busy=0, game_over=0 and level is one-hot valid.
  - On accept: latch pattern_flat, input_flat and len (from level) → CAPTURE.
  - enable with level 000 or non-one-hot: level_err pulses next cycle; no state change.
  - enable while busy or game_over: ignored silently.
- State CAPTURE: idx=0, hit_acc=0 → COMPARE.
- State COMPARE:
  - Each cycle compare captured entry idx; hit_acc += (pattern==input).
  - idx==len-1 → UPDATE, else idx++.
  - Exactly len cycles.
- State UPDATE:
  - round_hits←hit_acc; round_perfect←(hit_acc==len).
  - total_score←sat(total_score+hit_acc); saturates at 2^SCORE_W-1.
  - round_cnt++ → DONE.
- State DONE:
  - round_end=1 for this single cycle.
  - game_over←1 if round_cnt==NUM_ROUNDS.
  - → IDLE.
- Latency: enable accepted at edge t → round_end high during cycle t+len+3. Level 1 gives 7 cycles; level 3 gives 19.
- Live-input isolation: changes to pattern_flat, input_flat or level after capture do not affect the round in progress.
- Output hold: round_hits, round_perfect and total_score hold until the next UPDATE.
- Reset mid-round: immediate return to IDLE with all outputs 0; no partial score retained.
- round_cnt never exceeds NUM_ROUNDS; only reset restarts a game.
- Entries at idx ≥ len are never examined.

Optional Feature:
- Macro ROUND_JUDGE_PERFECT_BONUS_EN.
- Defined: in UPDATE, a perfect round adds hit_acc+len (double points, still saturating). round_perfect also feeds this bonus.
- Undefined: adds hit_acc only; round_perfect is still reported.

Decomposition:
- Shared package game_pkg:
  - LV1/LV2/LV3/LV_INVALID encodings (001/010/100/000).
  - ENTRY_W=3, MAX_LEN=16, judge state enum (IDLE, CAPTURE, COMPARE, UPDATE, DONE).
- Sub-module round_len_decode: combinational level→{len[4:0], valid}. Reusable by print_pattern and input_trim.

Test Plan:
- Level 001, pattern=input=entries {3,1,7,0}, enable pulse → round_end at edge t+7; round_hits=4, round_perfect=1, total_score=4 (8 with bonus), round_cnt=1.
- Level 100, input matches pattern only at even entries → round_hits=8, round_perfect=0, round_end at edge t+19.
- Level 000 with enable → level_err one pulse; busy stays 0; no counters change.
- Second enable during COMPARE and pattern_flat changed mid-round → ignored; result reflects the captured data only.
- Ten level-010 rounds, each with 5 hits → total_score=50, round_cnt=10, game_over=1. An 11th enable is ignored.
- rst low during COMPARE of round 3 → all outputs 0 immediately; a fresh round afterwards yields round_cnt=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: level encodings, entry geometry and the round-judge
// state encoding. Imported by round_judge and round_len_decode.
package game_pkg;

  localparam int unsigned ENTRY_W = 3;   // bits per pattern/input entry
  localparam int unsigned MAX_LEN = 16;  // entries carried on the flat buses
  localparam int unsigned LEN_W   = 5;   // holds 0..MAX_LEN
  localparam int unsigned IDX_W   = 4;   // holds 0..MAX_LEN-1
  localparam int unsigned LEVEL_W = 3;

  localparam logic [LEVEL_W-1:0] LV1        = 3'b001;
  localparam logic [LEVEL_W-1:0] LV2        = 3'b010;
  localparam logic [LEVEL_W-1:0] LV3        = 3'b100;
  localparam logic [LEVEL_W-1:0] LV_INVALID = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    COMPARE = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } judge_state_t;

endpackage

// File: rtl/round_len_decode.sv
// Combinational level -> round length decoder.
// Ports: level (one-hot 001/010/100), len_c (entries to judge), valid_c
// (level is one of the three legal one-hot codes; len_c is 0 otherwise).
module round_len_decode
  import game_pkg::*;
#(
  parameter int unsigned LEN_LV1 = 4,
  parameter int unsigned LEN_LV2 = 8,
  parameter int unsigned LEN_LV3 = 16
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [LEN_W-1:0]   len_c,
  output logic               valid_c
);

  always_comb begin
    len_c   = '0;
    valid_c = 1'b0;
    case (level)
      LV1: begin len_c = LEN_W'(LEN_LV1); valid_c = 1'b1; end
      LV2: begin len_c = LEN_W'(LEN_LV2); valid_c = 1'b1; end
      LV3: begin len_c = LEN_W'(LEN_LV3); valid_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/round_judge.sv
// Round judge: on an enable pulse captures the pattern and trimmed input,
// compares one entry per cycle over the level-dependent length, then updates
// per-round and per-game results.
// Ports: clk, rst (async active-low), enable (start pulse), level (one-hot),
// pattern_flat/input_flat (16 x 3-bit entries), busy, round_end (pulse),
// round_hits, round_perfect, total_score (saturating), round_cnt, game_over
// (sticky), level_err (pulse on enable with an invalid level).
// Optional macro ROUND_JUDGE_PERFECT_BONUS_EN: a perfect round scores double.
module round_judge
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned LEN_LV1    = 4,
  parameter int unsigned LEN_LV2    = 8,
  parameter int unsigned LEN_LV3    = 16,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [LEVEL_W-1:0]         level,
  input  logic [MAX_LEN*ENTRY_W-1:0] pattern_flat,
  input  logic [MAX_LEN*ENTRY_W-1:0] input_flat,
  output logic                       busy,
  output logic                       round_end,
  output logic [LEN_W-1:0]           round_hits,
  output logic                       round_perfect,
  output logic [SCORE_W-1:0]         total_score,
  output logic [3:0]                 round_cnt,
  output logic                       game_over,
  output logic                       level_err
);

  localparam int unsigned ADD_W = LEN_W + 1;
  localparam int unsigned SUM_W = SCORE_W + 1;

  judge_state_t state_q, state_d;

  logic [MAX_LEN-1:0][ENTRY_W-1:0] pat_q, inp_q;
  logic [LEN_W-1:0]                len_q, hit_acc_q;
  logic [IDX_W-1:0]                idx_q;

  logic [LEN_W-1:0] dec_len_c;
  logic             dec_valid_c;
  logic             accept_c, err_c, last_c, match_c, perfect_c;
  logic             capture_en_c, clear_en_c, cmp_en_c, update_en_c, done_en_c;
  logic [ADD_W-1:0] add_c;
  logic [SUM_W-1:0] sum_c;

  round_len_decode #(
    .LEN_LV1 (LEN_LV1),
    .LEN_LV2 (LEN_LV2),
    .LEN_LV3 (LEN_LV3)
  ) u_len_decode (
    .level   (level),
    .len_c   (dec_len_c),
    .valid_c (dec_valid_c)
  );

  // Start qualification: only an idle, unfinished game takes a new round.
  assign accept_c  = enable && (state_q == IDLE) && !game_over && dec_valid_c;
  assign err_c     = enable && (state_q == IDLE) && !game_over && !dec_valid_c;
  assign last_c    = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  assign match_c   = (pat_q[idx_q] == inp_q[idx_q]);
  assign perfect_c = (hit_acc_q == len_q);

`ifdef ROUND_JUDGE_PERFECT_BONUS_EN
  assign add_c = perfect_c ? (ADD_W'(hit_acc_q) + ADD_W'(len_q)) : ADD_W'(hit_acc_q);
`else
  assign add_c = ADD_W'(hit_acc_q);
`endif

  // One spare bit catches overflow for saturation.
  assign sum_c = SUM_W'(total_score) + SUM_W'(add_c);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CAPTURE;
      CAPTURE: state_d = COMPARE;
      COMPARE: if (last_c) state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    capture_en_c = 1'b0;
    clear_en_c   = 1'b0;
    cmp_en_c     = 1'b0;
    update_en_c  = 1'b0;
    done_en_c    = 1'b0;
    case (state_q)
      IDLE:    capture_en_c = accept_c;
      CAPTURE: clear_en_c   = 1'b1;
      COMPARE: cmp_en_c     = 1'b1;
      UPDATE:  update_en_c  = 1'b1;
      DONE:    done_en_c    = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q         <= '0;
      inp_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      hit_acc_q     <= '0;
      busy          <= 1'b0;
      round_end     <= 1'b0;
      round_hits    <= '0;
      round_perfect <= 1'b0;
      total_score   <= '0;
      round_cnt     <= '0;
      game_over     <= 1'b0;
      level_err     <= 1'b0;
    end else begin
      busy      <= (state_d != IDLE);
      round_end <= (state_d == DONE);
      level_err <= err_c;

      if (capture_en_c) begin
        pat_q <= pattern_flat;
        inp_q <= input_flat;
        len_q <= dec_len_c;
      end

      if (clear_en_c) begin
        idx_q     <= '0;
        hit_acc_q <= '0;
      end

      if (cmp_en_c) begin
        hit_acc_q <= hit_acc_q + LEN_W'(match_c);
        if (!last_c) idx_q <= idx_q + IDX_W'(1);
      end

      if (update_en_c) begin
        round_hits    <= hit_acc_q;
        round_perfect <= perfect_c;
        total_score   <= sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
        if (round_cnt < 4'(NUM_ROUNDS)) round_cnt <= round_cnt + 4'd1;
      end

      if (done_en_c && (round_cnt == 4'(NUM_ROUNDS))) game_over <= 1'b1;
    end
  end

endmodule
